// File: rtl/ram64_loader.sv
// ram64_loader -- write sequencer in front of a 64x16 RAM64.
//
// Takes a valid/ready byte stream, packs byte pairs into 16-bit words and
// writes them to consecutive RAM addresses (a load job). A clear job writes
// FILL_VALUE to all 64 addresses instead. RAM read data is not used here.
//
// Parameters
//   BIG_ENDIAN   1: first byte of a pair -> word[15:8]; 0: -> word[7:0]
//   FILL_VALUE   word written to every address by a clear job
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   start, clear            job requests, sampled only while idle
//   base_addr, word_count   first address and length (1..64) of a load job
//   byte_in, byte_valid     stream input
//   byte_ready              stream handshake
//   ram_in, ram_load,
//   ram_address             RAM64 write pins
//   busy                    job in progress
//   done, error             one-cycle pulses: job finished / illegal count
//   checksum                sum of written words (RAM64_LOADER_CHECKSUM_EN)
//
// Build option: define RAM64_LOADER_CHECKSUM_EN to add the checksum port.

module ram64_loader #(
   parameter logic        BIG_ENDIAN = 1'b1,
   parameter logic [15:0] FILL_VALUE = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        clear,
   input  logic [5:0]  base_addr,
   input  logic [6:0]  word_count,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [15:0] ram_in,
   output logic        ram_load,
   output logic [5:0]  ram_address,
   output logic        busy,
   output logic        done,
   output logic        error
`ifdef RAM64_LOADER_CHECKSUM_EN
   ,
   output logic [15:0] checksum
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BYTE0 = 3'd1,
      S_BYTE1 = 3'd2,
      S_WRITE = 3'd3,
      S_FILL  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [6:0]  remain_q, remain_d;
   logic [7:0]  byte0_q, byte0_d;
   logic        error_d;
   logic        xfer_s;
   logic [15:0] packed_s;

   logic        byte_ready_q, byte_ready_d;
   logic [15:0] ram_in_q, ram_in_d;
   logic        ram_load_q, ram_load_d;
   logic [5:0]  ram_address_q, ram_address_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q;

   assign xfer_s   = byte_valid & byte_ready_q;
   assign packed_s = BIG_ENDIAN ? {byte0_q, byte_in} : {byte_in, byte0_q};

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= 6'd0;
         remain_q <= 7'd0;
         byte0_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         remain_q <= remain_d;
         byte0_q  <= byte0_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      remain_d = remain_q;
      byte0_d  = byte0_q;
      error_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clear) begin
               // clear wins over a simultaneous start
               state_d = S_FILL;
               ptr_d   = 6'd0;
            end else if (start) begin
               if ((word_count != 7'd0) && (word_count <= 7'd64)) begin
                  state_d  = S_BYTE0;
                  ptr_d    = base_addr;
                  remain_d = word_count;
               end else begin
                  error_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BYTE0: begin
            if (xfer_s) begin
               byte0_d = byte_in;
               state_d = S_BYTE1;
            end else begin
               state_d = S_BYTE0;
            end
         end
         S_BYTE1: begin
            if (xfer_s) begin
               state_d = S_WRITE;
            end else begin
               state_d = S_BYTE1;
            end
         end
         S_WRITE: begin
            ptr_d    = ptr_q + 6'd1;
            remain_d = remain_q - 7'd1;
            if (remain_q == 7'd1) begin
               state_d = S_DONE;
            end else begin
               state_d = S_BYTE0;
            end
         end
         S_FILL: begin
            // ptr doubles as the fill address counter
            ptr_d = ptr_q + 6'd1;
            if (ptr_q == 6'd63) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FILL;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so that every output is a flop
   always_comb begin
      byte_ready_d  = 1'b0;
      ram_load_d    = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b0;
      ram_address_d = ram_address_q;
      ram_in_d      = ram_in_q;
      case (state_d)
         S_BYTE0, S_BYTE1: begin
            byte_ready_d = 1'b1;
            busy_d       = 1'b1;
         end
         S_WRITE: begin
            // only reachable from BYTE1 with a transfer, so byte_in is the second byte
            ram_load_d    = 1'b1;
            busy_d        = 1'b1;
            ram_address_d = ptr_d;
            ram_in_d      = packed_s;
         end
         S_FILL: begin
            ram_load_d    = 1'b1;
            busy_d        = 1'b1;
            ram_address_d = ptr_d;
            ram_in_d      = FILL_VALUE;
         end
         S_DONE:  done_d = 1'b1;
         default: done_d = 1'b0;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_ready_q  <= 1'b0;
         ram_in_q      <= 16'd0;
         ram_load_q    <= 1'b0;
         ram_address_q <= 6'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         byte_ready_q  <= byte_ready_d;
         ram_in_q      <= ram_in_d;
         ram_load_q    <= ram_load_d;
         ram_address_q <= ram_address_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
      end
   end

   assign byte_ready  = byte_ready_q;
   assign ram_in      = ram_in_q;
   assign ram_load    = ram_load_q;
   assign ram_address = ram_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;

`ifdef RAM64_LOADER_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   // Accumulate each word as the RAM captures it; restart on any job launch
   always_comb begin
      if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
         checksum_d = 16'd0;
      end else if (ram_load_q) begin
         checksum_d = checksum_q + ram_in_q;
      end else begin
         checksum_d = checksum_q;
      end
   end

   // Checksum register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         checksum_q <= 16'd0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

endmodule
